// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, state encoding and defaults for the accumulator CPU controller
package cpu_pkg;

  localparam logic [1:0] OP_LDA = 2'b00;
  localparam logic [1:0] OP_STA = 2'b01;
  localparam logic [1:0] OP_JMP = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  localparam int WAIT_TIMEOUT_DEFAULT = 15;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EX_LDA = 3'd3,
    ST_EX_STA = 3'd4,
    ST_EX_JMP = 3'd5,
    ST_EX_ADD = 3'd6,
    ST_HALT   = 3'd7
  } state_t;

  // States that hold a memory strobe and wait for mem_ready
  function automatic logic is_mem_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_EX_LDA) || (s == ST_EX_STA);
  endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// rtl/cpu_controller_if.sv - controller <-> datapath/memory control bundle
interface cpu_controller_if;

  logic [1:0] op_code;
  logic       mem_ready;

  logic       ir_on_adr;
  logic       pc_on_adr;
  logic       data_on_dbus;
  logic       dbus_on_data;
  logic       alu_on_dbus;
  logic       ld_ir;
  logic       ld_ac;
  logic       ld_pc;
  logic       inc_pc;
  logic       clr_pc;
  logic       pass;
  logic       add;
  logic       mem_rd;
  logic       mem_wr;
  logic       halted;
  logic [7:0] instr_count;

  modport master (
    input  op_code, mem_ready,
    output ir_on_adr, pc_on_adr, data_on_dbus, dbus_on_data, alu_on_dbus,
           ld_ir, ld_ac, ld_pc, inc_pc, clr_pc, pass, add, mem_rd, mem_wr,
           halted, instr_count
  );

  modport slave (
    output op_code, mem_ready,
    input  ir_on_adr, pc_on_adr, data_on_dbus, dbus_on_data, alu_on_dbus,
           ld_ir, ld_ac, ld_pc, inc_pc, clr_pc, pass, add, mem_rd, mem_wr,
           halted, instr_count
  );

endinterface

// File: rtl/cpu_controller_wait_timer.sv
// rtl/cpu_controller_wait_timer.sv - memory wait-cycle counter with expiry flag
module wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // Expired means the current low cycle is the LIMIT-th one in a row
  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] count;

  // Count consecutive not-ready cycles; clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count >= LAST);

endmodule

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - fetch/decode/execute sequencer for the 8-bit accumulator CPU
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_DEFAULT
) (
  input logic              clk,
  input logic              rst_n,
  cpu_controller_if.master bus
);

  state_t     state;
  state_t     state_next;
  logic       in_mem;
  logic       timer_clear;
  logic       timer_enable;
  logic       timer_expired;
  logic       retire;
  logic [7:0] count;

  // The timer only runs while a memory state is stalled; any other state
  // or a completed transfer clears it, which also covers state entry.
  assign in_mem       = is_mem_state(state);
  assign timer_clear  = !in_mem || bus.mem_ready;
  assign timer_enable = in_mem && !bus.mem_ready;

  wait_timer #(
    .LIMIT(WAIT_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(timer_expired)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RESET;
    end else begin
      state <= state_next;
    end
  end

  // Retired-instruction counter, wraps naturally at 8 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (retire) begin
      count <= count + 8'd1;
    end
  end

  assign bus.instr_count = count;

  // Next state and strobes; load strobes in memory states wait for mem_ready
  always_comb begin
    state_next       = state;
    retire           = 1'b0;
    bus.ir_on_adr    = 1'b0;
    bus.pc_on_adr    = 1'b0;
    bus.data_on_dbus = 1'b0;
    bus.dbus_on_data = 1'b0;
    bus.alu_on_dbus  = 1'b0;
    bus.ld_ir        = 1'b0;
    bus.ld_ac        = 1'b0;
    bus.ld_pc        = 1'b0;
    bus.inc_pc       = 1'b0;
    bus.clr_pc       = 1'b0;
    bus.pass         = 1'b0;
    bus.add          = 1'b0;
    bus.mem_rd       = 1'b0;
    bus.mem_wr       = 1'b0;
    bus.halted       = 1'b0;

    case (state)
      ST_RESET: begin
        bus.clr_pc = 1'b1;
        state_next = ST_FETCH;
      end

      ST_FETCH: begin
        bus.pc_on_adr    = 1'b1;
        bus.mem_rd       = 1'b1;
        bus.data_on_dbus = 1'b1;
        if (bus.mem_ready) begin
          bus.ld_ir  = 1'b1;
          bus.inc_pc = 1'b1;
          state_next = ST_DECODE;
        end else if (timer_expired) begin
          state_next = ST_HALT;
        end
      end

      ST_DECODE: begin
        case (bus.op_code)
          OP_LDA:  state_next = ST_EX_LDA;
          OP_STA:  state_next = ST_EX_STA;
          OP_JMP:  state_next = ST_EX_JMP;
          default: state_next = ST_EX_ADD;
        endcase
      end

      ST_EX_LDA: begin
        bus.ir_on_adr    = 1'b1;
        bus.mem_rd       = 1'b1;
        bus.data_on_dbus = 1'b1;
        if (bus.mem_ready) begin
          bus.ld_ac  = 1'b1;
          retire     = 1'b1;
          state_next = ST_FETCH;
        end else if (timer_expired) begin
          state_next = ST_HALT;
        end
      end

      ST_EX_STA: begin
        bus.ir_on_adr    = 1'b1;
        bus.pass         = 1'b1;
        bus.alu_on_dbus  = 1'b1;
        bus.dbus_on_data = 1'b1;
        bus.mem_wr       = 1'b1;
        if (bus.mem_ready) begin
          retire     = 1'b1;
          state_next = ST_FETCH;
        end else if (timer_expired) begin
          state_next = ST_HALT;
        end
      end

      ST_EX_JMP: begin
        bus.ld_pc  = 1'b1;
        retire     = 1'b1;
        state_next = ST_FETCH;
      end

      ST_EX_ADD: begin
        bus.add         = 1'b1;
        bus.alu_on_dbus = 1'b1;
        bus.ld_ac       = 1'b1;
        retire          = 1'b1;
        state_next      = ST_FETCH;
      end

      ST_HALT: begin
        bus.halted = 1'b1;
        state_next = ST_HALT;
      end

      default: begin
        state_next = ST_RESET;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - self-checking bench: datapath/memory stand-in plus instruction-level model
module tb_cpu_controller;

  localparam int TO   = 4;
  localparam int LOGN = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  cpu_controller_if bus ();

  cpu_controller #(
    .WAIT_TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Datapath and memory driven by the DUT's strobes
  logic [7:0] dp_mem [64];
  logic [7:0] dp_ac;
  logic [7:0] dp_ir;
  logic [5:0] dp_pc;

  assign bus.op_code = dp_ir[7:6];

  // Instruction-level reference: what the CPU must be doing each cycle
  typedef enum int {M_RESET, M_FETCH, M_DECODE, M_EXEC, M_HALT} mphase_t;
  mphase_t    m_phase;
  logic [7:0] m_mem [64];
  logic [7:0] m_ac;
  logic [7:0] m_ir;
  logic [7:0] m_count;
  logic [5:0] m_pc;
  int         m_waits;

  // Per-cycle record after each reset release, for literal checks
  logic [14:0] out_log [LOGN];
  logic [7:0]  cnt_log [LOGN];
  logic [7:0]  ac_log  [LOGN];
  logic [5:0]  pc_log  [LOGN];
  int          cyc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Bit order: ir_on_adr pc_on_adr data_on_dbus dbus_on_data alu_on_dbus ld_ir ld_ac
  //            ld_pc inc_pc clr_pc pass add mem_rd mem_wr halted
  function automatic logic [14:0] dut_vec();
    return {bus.ir_on_adr, bus.pc_on_adr, bus.data_on_dbus, bus.dbus_on_data,
            bus.alu_on_dbus, bus.ld_ir, bus.ld_ac, bus.ld_pc, bus.inc_pc,
            bus.clr_pc, bus.pass, bus.add, bus.mem_rd, bus.mem_wr, bus.halted};
  endfunction

  function automatic logic [14:0] model_vec(input logic r);
    logic [14:0] v;
    v = '0;
    case (m_phase)
      M_RESET: v[5] = 1'b1;
      M_FETCH: begin
        v[13] = 1'b1; v[12] = 1'b1; v[2] = 1'b1;
        v[9] = r; v[6] = r;
      end
      M_EXEC: begin
        case (m_ir[7:6])
          2'd0: begin v[14] = 1'b1; v[12] = 1'b1; v[2] = 1'b1; v[8] = r; end
          2'd1: begin v[14] = 1'b1; v[4] = 1'b1; v[10] = 1'b1; v[11] = 1'b1; v[1] = 1'b1; end
          2'd2: v[7] = 1'b1;
          default: begin v[3] = 1'b1; v[10] = 1'b1; v[8] = 1'b1; end
        endcase
      end
      M_HALT: v[0] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_stall();
    m_waits++;
    if (m_waits >= TO) m_phase = M_HALT;
  endtask

  task automatic model_retire();
    m_count = m_count + 8'd1;
    m_waits = 0;
    m_phase = M_FETCH;
  endtask

  task automatic model_step(input logic r);
    case (m_phase)
      M_RESET: begin m_pc = 6'd0; m_waits = 0; m_phase = M_FETCH; end
      M_FETCH: begin
        if (r) begin
          m_ir = m_mem[m_pc]; m_pc = m_pc + 6'd1; m_waits = 0; m_phase = M_DECODE;
        end else model_stall();
      end
      M_DECODE: begin m_waits = 0; m_phase = M_EXEC; end
      M_EXEC: begin
        case (m_ir[7:6])
          2'd0: if (r) begin m_ac = m_mem[m_ir[5:0]]; model_retire(); end else model_stall();
          2'd1: if (r) begin m_mem[m_ir[5:0]] = m_ac; model_retire(); end else model_stall();
          2'd2: begin m_pc = m_ir[5:0]; model_retire(); end
          default: begin m_ac = m_ac + {2'b00, m_ir[5:0]}; model_retire(); end
        endcase
      end
      default: m_phase = M_HALT;
    endcase
  endtask

  // Compare outputs every cycle, then advance datapath and model
  always @(negedge clk) begin : cmp
    logic [14:0] got;
    logic [14:0] expv;
    logic [7:0]  rd;
    logic [5:0]  adr;
    logic        r;
    r    = bus.mem_ready;
    got  = dut_vec();
    expv = model_vec(r);
    check("strobes", 32'(got), 32'(expv));
    check("instr_count", 32'(bus.instr_count), 32'(m_count));
    if (rst_n && cyc < LOGN) begin
      out_log[cyc] = got;
      cnt_log[cyc] = bus.instr_count;
      pc_log[cyc]  = dp_pc;
    end
    adr = got[13] ? dp_pc : dp_ir[5:0];
    rd  = dp_mem[adr];
    if (got[1] && r) dp_mem[adr] = dp_ac;
    if (got[8]) dp_ac = got[3] ? dp_ac + {2'b00, dp_ir[5:0]} : rd;
    if (got[6]) dp_pc = dp_pc + 6'd1;
    if (got[7]) dp_pc = dp_ir[5:0];
    if (got[9]) dp_ir = rd;
    if (got[5]) dp_pc = 6'd0;
    if (rst_n && cyc < LOGN) ac_log[cyc] = dp_ac;
    if (rst_n) begin
      model_step(r);
      cyc++;
    end else begin
      cyc = 0;
    end
  end

  task automatic assert_reset();
    rst_n   = 1'b0;
    m_phase = M_RESET;
    m_count = 8'd0;
    m_waits = 0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic fill_mem(input logic [7:0] val, input logic [7:0] ac);
    for (int i = 0; i < 64; i++) begin
      dp_mem[i] = val;
      m_mem[i]  = val;
    end
    dp_ac = ac;
    m_ac  = ac;
  endtask

  task automatic poke(input int a, input logic [7:0] val);
    dp_mem[a] = val;
    m_mem[a]  = val;
  endtask

  initial begin
    logic [27:0] rdy;
    int          mism;
    bus.mem_ready = 1'b1;
    dp_ir = 8'd0; dp_pc = 6'd0;
    m_ir  = 8'd0; m_pc  = 6'd0;
    assert_reset();

    // Directed program: ADD 5, LDA 0x0A, STA 0x0F, JMP 0x12, ADD 1, stalled fetch
    fill_mem(8'h00, 8'h03);
    poke(0, 8'hC5); poke(1, 8'h0A); poke(2, 8'h4F); poke(3, 8'h92);
    poke(8'h0A, 8'h21); poke(8'h12, 8'hC1);
    repeat (2) @(posedge clk);
    rdy = 28'h038FE3F;
    release_reset();
    for (int i = 0; i < 28; i++) begin
      bus.mem_ready = rdy[i];
      @(posedge clk);
      #1;
    end
    check("reset_vec", 32'(out_log[0]), 32'h0020);
    check("reset_count", 32'(cnt_log[0]), 32'd0);
    check("fetch_ready", 32'(out_log[1]), 32'h3244);
    check("decode_idle", 32'(out_log[2]), 32'h0000);
    check("add_strobes", 32'(out_log[3]), 32'h0508);
    check("ac_after_add", 32'(ac_log[3]), 32'h08);
    check("count_after_add", 32'(cnt_log[4]), 32'd1);
    for (int i = 6; i < 9; i++) check("lda_wait", 32'(out_log[i]), 32'h5004);
    check("lda_done", 32'(out_log[9]), 32'h5104);
    check("ac_after_lda", 32'(ac_log[9]), 32'h21);
    check("sta_strobes", 32'(out_log[12]), 32'h4C12);
    check("sta_mem", 32'(dp_mem[15]), 32'h21);
    check("jmp_strobes", 32'(out_log[15]), 32'h0080);
    check("jmp_target_adr", 32'(pc_log[16]), 32'h12);
    check("fetch_wait", 32'(out_log[16]), 32'h3004);
    check("ready_on_expiry", 32'(out_log[19]), 32'h3244);
    check("ac_after_add1", 32'(ac_log[21]), 32'h22);
    check("last_wait", 32'(out_log[25]), 32'h3004);
    check("halt_vec", 32'(out_log[26]), 32'h0001);
    check("halt_count", 32'(cnt_log[26]), 32'd5);

    // Reset while STA is stalled: write must not complete
    assert_reset();
    fill_mem(8'h00, 8'h77);
    poke(0, 8'h4F);
    repeat (2) @(posedge clk);
    bus.mem_ready = 1'b1;
    release_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.mem_ready = 1'b0;
    @(negedge clk);
    #2;
    check("sta_wr_active", 32'(bus.mem_wr), 32'd1);
    assert_reset();
    #1;
    check("async_mem_wr", 32'(bus.mem_wr), 32'd0);
    check("async_vec", 32'(dut_vec()), 32'h0020);
    repeat (2) @(posedge clk);
    #1;
    check("no_partial_write", 32'(dp_mem[15]), 32'h00);

    // 256 ADDs: retired count wraps to zero
    fill_mem(8'hC5, 8'h00);
    bus.mem_ready = 1'b1;
    release_reset();
    repeat (767) @(negedge clk);
    #1;
    check("count_255", 32'(bus.instr_count), 32'd255);
    repeat (3) @(negedge clk);
    #1;
    check("count_wrap", 32'(bus.instr_count), 32'd0);

    // Random program and memory latency; halts are recovered by reset
    assert_reset();
    for (int i = 0; i < 64; i++) poke(i, 8'($urandom));
    dp_ac = 8'($urandom);
    m_ac  = dp_ac;
    repeat (2) @(posedge clk);
    release_reset();
    for (int i = 0; i < 3000; i++) begin
      bus.mem_ready = ($urandom_range(0, 99) >= 30);
      @(negedge clk);
      #1;
      if (m_phase == M_HALT) begin
        assert_reset();
        repeat (2) @(posedge clk);
        release_reset();
      end else begin
        @(posedge clk);
        #1;
      end
    end
    check("final_ac", 32'(dp_ac), 32'(m_ac));
    mism = 0;
    for (int i = 0; i < 64; i++) if (dp_mem[i] !== m_mem[i]) mism++;
    check("final_mem", 32'(mism), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
